// File: rtl/ram_burst_ctrl_if.sv
// Burst request / write-stream / read-stream bundle between a requester and ram_burst_ctrl.
// The RAM-side pins (including the bidirectional data bus) stay plain ports on the controller.
interface ram_burst_ctrl_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;

    // Requester side.
    modport master (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, busy, done
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, busy, done
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst master for a single-port RAM with a shared bidirectional data bus.
// A request is accepted in IDLE, streamed as WR or RD beats with wrapping address
// increment, then closed by a single TURN cycle in which nobody drives the bus.
module ram_burst_ctrl #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ram_burst_ctrl_if.slave       bus,
    output logic                  o_ram_ena,
    output logic                  o_ram_wena,
    output logic [AW-1:0]         o_ram_addr,
    inout  wire  [DW-1:0]         io_ram_data
);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StTurn} state_e;

    localparam logic [AW-1:0] AddrOne = AW'(1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_cnt;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          w_drive;
    logic          w_last;

    // Final beat of the burst: count has reached the latched length.
    assign w_last = (r_cnt == r_len);

    // Controller only ever drives the shared bus while presenting a valid write beat.
    assign io_ram_data = w_drive ? bus.wr_data : {DW{1'bz}};

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and decoded outputs; only wr_valid passes through combinationally (in WR).
    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        o_ram_ena     = 1'b0;
        o_ram_wena    = 1'b0;
        o_ram_addr    = '0;
        w_drive       = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    w_state_nxt = bus.req_write ? StWr : StRd;
                end
            end
            StWr: begin
                bus.wr_ready = 1'b1;
                o_ram_wena   = 1'b1;
                o_ram_ena    = bus.wr_valid;
                o_ram_addr   = r_addr;
                w_drive      = bus.wr_valid;
                if (bus.wr_valid && w_last) begin
                    w_state_nxt = StTurn;
                end
            end
            StRd: begin
                o_ram_ena  = 1'b1;
                o_ram_addr = r_addr;
                if (w_last) begin
                    w_state_nxt = StTurn;
                end
            end
            StTurn: begin
                bus.done    = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Address/count tracking and read-beat capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_addr <= bus.req_addr;
                        r_len  <= bus.req_len;
                        r_cnt  <= '0;
                    end
                end
                StWr: begin
                    // A stalled beat (wr_valid low) leaves address and count untouched.
                    if (bus.wr_valid) begin
                        r_addr <= r_addr + AddrOne;
                        r_cnt  <= r_cnt + AddrOne;
                    end
                end
                StRd: begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= io_ram_data;
                    r_addr     <= r_addr + AddrOne;
                    r_cnt      <= r_cnt + AddrOne;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
